// File: rtl/hall98_sequencer.sv
// hall98_sequencer: op FIFO plus issue FSM that feeds the hall98 core.
// Build option: HALL98_SEQ_OPCNT_EN adds the opcnt[15:0] issued-op counter.
//
// Ports:
//   iclock, ireset                      clock (rising), sync active-high reset
//   push_valid/push_ready               host push handshake
//   push_op/push_re/push_n              op fields pushed by the host
//   start, abort                        run control
//   sw1, sw2, re, n, cpu_valid          current op presented to the core
//   flag, busy, count                   run done, issuing, FIFO occupancy
//   opcnt                               ops issued since reset (option)
module hall98_sequencer #(
  parameter int DEPTH    = 8,
  parameter int RW       = 3,
  parameter int NW       = 8,
  parameter int HOLD_CYC = 5,
  localparam int AW      = $clog2(DEPTH),
  localparam int DEPTH_W = AW + 1
) (
  input  logic               iclock,
  input  logic               ireset,
  input  logic               push_valid,
  output logic               push_ready,
  input  logic [1:0]         push_op,
  input  logic [RW-1:0]      push_re,
  input  logic [NW-1:0]      push_n,
  input  logic               start,
  input  logic               abort,
  output logic               sw1,
  output logic               sw2,
  output logic [RW-1:0]      re,
  output logic [NW-1:0]      n,
  output logic               cpu_valid,
  output logic               flag,
  output logic               busy,
  output logic [DEPTH_W-1:0] count
`ifdef HALL98_SEQ_OPCNT_EN
  ,
  output logic [15:0]        opcnt
`endif
);

  localparam int HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [HW-1:0] HMAX = HW'(HOLD_CYC - 1);
  localparam int EW = 2 + RW + NW;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state, state_d;
  logic [HW-1:0] hold, hold_d;
  logic [DEPTH_W-1:0] wr, rd;
  logic [EW-1:0] mem [DEPTH];

  logic full, empty, do_push;
  logic load, finish;

  // Extra wrap bit distinguishes full from empty.
  assign empty = (wr == rd);
  assign full  = (wr[AW] != rd[AW]) &&
                 (wr[AW-1:0] == rd[AW-1:0]);
  assign do_push = push_valid && !full && !abort;

  assign push_ready = !full;
  assign count      = wr - rd;
  assign busy       = (state == ISSUE);

  always_comb begin
    state_d = state;
    hold_d  = hold;
    load    = 1'b0;
    finish  = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          hold_d = '0;
          if (!empty) begin
            load    = 1'b1;
            state_d = ISSUE;
          end else begin
            finish  = 1'b1;
            state_d = DONE;
          end
        end
      end
      ISSUE: begin
        if (hold == HMAX) begin
          hold_d = '0;
          // Back-to-back load keeps the core fed with no gap.
          if (!empty) begin
            load = 1'b1;
          end else begin
            finish  = 1'b1;
            state_d = DONE;
          end
        end else begin
          hold_d = hold + HW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d = IDLE;
      hold_d  = '0;
      load    = 1'b0;
      finish  = 1'b0;
    end
  end

  always_ff @(posedge iclock) begin
    if (do_push) begin
      mem[wr[AW-1:0]] <= {push_op, push_re, push_n};
    end
  end

  always_ff @(posedge iclock) begin
    if (ireset) begin
      state     <= IDLE;
      hold      <= '0;
      wr        <= '0;
      rd        <= '0;
      sw1       <= 1'b0;
      sw2       <= 1'b0;
      re        <= '0;
      n         <= '0;
      cpu_valid <= 1'b0;
      flag      <= 1'b0;
    end else begin
      state <= state_d;
      hold  <= hold_d;
      if (abort) begin
        wr <= '0;
        rd <= '0;
      end else begin
        wr <= wr + DEPTH_W'(do_push);
        rd <= rd + DEPTH_W'(load);
      end
      if (abort || finish) begin
        sw1       <= 1'b0;
        sw2       <= 1'b0;
        re        <= '0;
        n         <= '0;
        cpu_valid <= 1'b0;
      end else if (load) begin
        {sw1, sw2, re, n} <= mem[rd[AW-1:0]];
        cpu_valid <= 1'b1;
      end
      if (abort || load) begin
        flag <= 1'b0;
      end else if (finish) begin
        flag <= 1'b1;
      end
    end
  end

`ifdef HALL98_SEQ_OPCNT_EN
  // Survives abort; only reset clears it.
  always_ff @(posedge iclock) begin
    if (ireset) begin
      opcnt <= '0;
    end else if (load) begin
      opcnt <= opcnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hall98_sequencer.sv
// tb_hall98_sequencer: table vectors plus a scoreboard of issued ops.
// Expected ops are queued at push time and checked while presented.
module tb_hall98_sequencer;

  localparam int RW   = 3;
  localparam int NW   = 8;
  localparam int HOLD = 5;
  localparam int DW   = 4;

  logic iclock = 1'b0;
  logic ireset, push_valid, push_ready, start, abort;
  logic sw1, sw2, cpu_valid, flag, busy;
  logic [1:0] push_op;
  logic [RW-1:0] push_re, re;
  logic [NW-1:0] push_n, n;
  logic [DW-1:0] count;
`ifdef HALL98_SEQ_OPCNT_EN
  logic [15:0] opcnt;
  int exp_opcnt = 0;
`endif

  typedef struct {
    logic [1:0]    op;
    logic [RW-1:0] re;
    logic [NW-1:0] n;
    logic          s1;
    logic          s2;
    logic          rdy;
    int            cnt;
  } vec_t;

  typedef struct {
    logic          s1;
    logic          s2;
    logic [RW-1:0] re;
    logic [NW-1:0] n;
  } exp_t;

  exp_t expq[$];
  vec_t tbl[9];
  vec_t inj;
  int checks = 0;
  int errors = 0;

  hall98_sequencer dut (
    .iclock(iclock), .ireset(ireset),
    .push_valid(push_valid), .push_ready(push_ready),
    .push_op(push_op), .push_re(push_re), .push_n(push_n),
    .start(start), .abort(abort),
    .sw1(sw1), .sw2(sw2), .re(re), .n(n),
    .cpu_valid(cpu_valid), .flag(flag), .busy(busy),
    .count(count)
`ifdef HALL98_SEQ_OPCNT_EN
    , .opcnt(opcnt)
`endif
  );

  always #5 iclock = ~iclock;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h",
               nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge iclock);
    #1;
  endtask

  task automatic push(input vec_t v);
    push_valid = 1'b1;
    push_op = v.op;
    push_re = v.re;
    push_n  = v.n;
    if (push_ready && !abort)
      expq.push_back('{v.s1, v.s2, v.re, v.n});
    step();
    push_valid = 1'b0;
  endtask

  task automatic chk_idle(input string nm, input logic f);
    chk(nm, {cpu_valid, busy, flag, sw1, sw2, re, n},
        {1'b0, 1'b0, f, 1'b0, 1'b0, 3'd0, 8'd0});
  endtask

  // Pulse start, then every presented cycle must match the queue head.
  task automatic run(input string tag, input int inj_at);
    exp_t e;
    int c = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    while (expq.size() > 0) begin
      e = expq.pop_front();
`ifdef HALL98_SEQ_OPCNT_EN
      exp_opcnt++;
`endif
      for (int h = 0; h < HOLD; h++) begin
        chk({tag, " op"},
            {cpu_valid, busy, flag, sw1, sw2, e.re, n},
            {1'b1, 1'b1, 1'b0, e.s1, e.s2, re, e.n});
        if (c == inj_at) begin
          push_valid = 1'b1;
          push_op = inj.op;
          push_re = inj.re;
          push_n  = inj.n;
          start   = 1'b1;
          if (push_ready)
            expq.push_back('{inj.s1, inj.s2, inj.re, inj.n});
        end
        step();
        push_valid = 1'b0;
        start = 1'b0;
        c++;
      end
    end
    chk_idle({tag, " done"}, 1'b1);
`ifdef HALL98_SEQ_OPCNT_EN
    chk({tag, " opcnt"}, 32'(opcnt), 32'(exp_opcnt));
`endif
  endtask

  initial begin
    tbl[0] = '{2'b10, 3'd1, 8'd15, 1'b1, 1'b0, 1'b1, 1};
    tbl[1] = '{2'b10, 3'd2, 8'd5,  1'b1, 1'b0, 1'b1, 2};
    tbl[2] = '{2'b01, 3'd1, 8'd2,  1'b0, 1'b1, 1'b1, 3};
    tbl[3] = '{2'b11, 3'd7, 8'hA5, 1'b1, 1'b1, 1'b1, 4};
    tbl[4] = '{2'b00, 3'd4, 8'h3C, 1'b0, 1'b0, 1'b1, 5};
    tbl[5] = '{2'b01, 3'd6, 8'hFF, 1'b0, 1'b1, 1'b1, 6};
    tbl[6] = '{2'b10, 3'd3, 8'h00, 1'b1, 1'b0, 1'b1, 7};
    tbl[7] = '{2'b11, 3'd5, 8'h81, 1'b1, 1'b1, 1'b1, 8};
    tbl[8] = '{2'b00, 3'd2, 8'h77, 1'b0, 1'b0, 1'b0, 8};

    ireset = 1'b1;
    push_valid = 1'b0;
    push_op = '0;
    push_re = '0;
    push_n  = '0;
    start = 1'b0;
    abort = 1'b0;
    step();
    step();
    ireset = 1'b0;
    chk_idle("reset outs", 1'b0);
    chk("reset ready", 32'(push_ready), 32'd1);
    chk("reset count", 32'(count), 32'd0);
`ifdef HALL98_SEQ_OPCNT_EN
    chk("reset opcnt", 32'(opcnt), 32'd0);
`endif

    // Three ops, flag on cycle 16 after start.
    for (int i = 0; i < 3; i++) push(tbl[i]);
    chk("s2 count", 32'(count), 32'd3);
    run("s2", -1);

    // Push plus ignored start while issuing.
    push('{2'b01, 3'd3, 8'd7, 1'b0, 1'b1, 1'b1, 1});
    inj = '{2'b10, 3'd4, 8'd9, 1'b1, 1'b0, 1'b1, 0};
    run("s7", 1);

    // Fill to full, overflow push, drain.
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("s3 ready%0d", i),
          32'(push_ready), 32'(tbl[i].rdy));
      push(tbl[i]);
      chk($sformatf("s3 count%0d", i),
          32'(count), 32'(tbl[i].cnt));
    end
    chk("s3 full ready", 32'(push_ready), 32'd0);
    chk("s3 done held", 32'({flag, busy}), 32'b10);
    run("s3", -1);

    // Abort during the second op.
    for (int i = 0; i < 4; i++) push(tbl[i]);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int h = 0; h < HOLD + 2; h++) step();
    chk("s4 2nd op", {cpu_valid, sw1, sw2, re, n, count},
        {1'b1, 1'b1, 1'b0, 3'd2, 8'd5, 4'd2});
    abort = 1'b1;
    push_valid = 1'b1;
    start = 1'b1;
    step();
    abort = 1'b0;
    push_valid = 1'b0;
    start = 1'b0;
    expq.delete();
`ifdef HALL98_SEQ_OPCNT_EN
    exp_opcnt += 2;
`endif
    chk_idle("s4 abort outs", 1'b0);
    chk("s4 abort fifo", 32'({push_ready, count}), 32'h10);
    for (int h = 0; h < 10; h++) step();
    chk_idle("s4 stays idle", 1'b0);
`ifdef HALL98_SEQ_OPCNT_EN
    chk("s4 opcnt kept", 32'(opcnt), 32'(exp_opcnt));
`endif

    // Start on empty FIFO, then SUB pushed in DONE.
    start = 1'b1;
    step();
    start = 1'b0;
    chk_idle("s5 empty start", 1'b1);
    push('{2'b11, 3'd1, 8'd2, 1'b1, 1'b1, 1'b1, 1});
    chk("s5 done push", 32'({flag, busy, count}), 32'h21);
    run("s5", -1);

    // Reset in the middle of a run.
    push(tbl[3]);
    push(tbl[4]);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    ireset = 1'b1;
    step();
    ireset = 1'b0;
    expq.delete();
    chk_idle("s8 reset outs", 1'b0);
    chk("s8 reset fifo", 32'({push_ready, count}), 32'h10);
`ifdef HALL98_SEQ_OPCNT_EN
    chk("s8 reset opcnt", 32'(opcnt), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
